// File: rtl/priority_arbiter_pkg.sv
// priority_arbiter_pkg
//   Shared types and constants for the four-requester priority arbiter.
//   - N_REQ   : number of requesters
//   - ID_W    : width of the binary grant index
//   - state_e : arbiter FSM states (IDLE, GRANT, RELEASE)
//   - id_to_onehot : converts a grant index into a one-hot grant vector
package priority_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/priority_encoder_4_2.sv
// priority_encoder_4_2
//   Combinational 4-to-2 priority encoder; the highest set bit wins.
//   Ports:
//     req_i   [3:0] : request vector
//     id_o    [1:0] : index of the highest set bit (0 when req_i is zero)
//     valid_o       : 1 when any bit of req_i is set
module priority_encoder_4_2
  import priority_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  output logic [ID_W-1:0]  id_o,
  output logic             valid_o
);

  always_comb begin
    id_o = '0;
    if (req_i[3])      id_o = 2'd3;
    else if (req_i[2]) id_o = 2'd2;
    else if (req_i[1]) id_o = 2'd1;
    else               id_o = 2'd0;
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/priority_arbiter_4.sv
// priority_arbiter_4
//   Four-requester arbiter for one shared resource. Priority-encodes the
//   request vector, registers a one-hot grant plus its binary index, and
//   holds the grant until the owner drops its request or MAX_HOLD cycles
//   have elapsed. A single RELEASE cycle (gnt = 0) separates consecutive
//   grants, including a re-grant to the same requester.
//
//   Optional feature macro: PRIORITY_ARBITER_RR_EN
//     defined   : rotating priority; the previous owner becomes lowest
//                 priority (order after owner k: k-1, k-2, ..., k).
//     undefined : fixed priority 3 > 2 > 1 > 0.
//
//   Parameters:
//     MAX_HOLD : maximum consecutive grant cycles per owner (2..256)
//   Ports:
//     clk       : rising-edge clock
//     rst       : asynchronous active-high reset
//     req       [3:0] : level requests
//     gnt       [3:0] : registered one-hot grant, zero when no owner
//     gnt_id    [1:0] : binary owner index, meaningful only with gnt_valid
//     gnt_valid       : registered copy of |gnt
//     timeout         : one-cycle pulse in the RELEASE cycle after a
//                       grant was revoked by the hold limit
module priority_arbiter_4
  import priority_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int              CNT_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic [N_REQ-1:0]  req_rot;
  logic [ID_W-1:0]   enc_id;
  logic              enc_vld;
  logic [ID_W-1:0]   win_id;

`ifdef PRIORITY_ARBITER_RR_EN
  logic [ID_W-1:0]      last_q, last_d;
  logic [2*N_REQ-1:0]   req_dbl;

  // Rotate so that req[last] lands on bit 0 (lowest priority) and
  // req[last-1] lands on bit 3 (highest); the encoder result is then
  // mapped back with modular addition.
  assign req_dbl = {req, req} >> last_q;
  assign req_rot = req_dbl[N_REQ-1:0];
  assign win_id  = enc_id + last_q;
`else
  assign req_rot = req;
  assign win_id  = enc_id;
`endif

  priority_encoder_4_2 u_pick (
    .req_i   (req_rot),
    .id_o    (enc_id),
    .valid_o (enc_vld)
  );

  // Rotation preserves the OR of the vector, so enc_vld is |req.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
`ifdef PRIORITY_ARBITER_RR_EN
    last_d      = last_q;
`endif

    unique case (state_q)
      IDLE, RELEASE: begin
        gnt_d = '0;
        if (enc_vld) begin
          gnt_d      = id_to_onehot(win_id);
          gnt_id_d   = win_id;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end else begin
          state_d    = IDLE;
        end
      end

      GRANT: begin
        hold_cnt_d = (hold_cnt_q == CNT_MAX) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
        // Owner drop is checked first so it beats a simultaneous limit hit.
        if (!req[gnt_id_q]) begin
          gnt_d   = '0;
          state_d = RELEASE;
`ifdef PRIORITY_ARBITER_RR_EN
          last_d  = gnt_id_q;
`endif
        end else if (hold_cnt_q == CNT_MAX) begin
          gnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = RELEASE;
`ifdef PRIORITY_ARBITER_RR_EN
          last_d    = gnt_id_q;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

`ifdef PRIORITY_ARBITER_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= '0;
    else     last_q <= last_d;
  end
`endif

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_priority_arbiter_4.sv
module tb_priority_arbiter_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  string cur_test = "reset";

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  priority_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] oh(input int id);
    logic [3:0] v;
    v = 4'b0000;
    v[id[1:0]] = 1'b1;
    return v;
  endfunction

  // Monitor: one expectation per clock, compared 1 time unit after the edge.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (gnt !== mon_e.gnt || gnt_valid !== (|mon_e.gnt) || timeout !== mon_e.to ||
          ((|mon_e.gnt) && gnt_id !== mon_e.id)) begin
        errors++;
        $display("FAIL cyc%0d %s: got gnt=%b id=%0d vld=%b to=%b, want gnt=%b id=%0d vld=%b to=%b",
                 cyc, cur_test, gnt, gnt_id, gnt_valid, timeout,
                 mon_e.gnt, mon_e.id, |mon_e.gnt, mon_e.to);
      end
    end
  end

  // Apply req for the next edge and queue the outputs expected after it.
  task automatic drive(input logic [3:0] r, input logic [3:0] eg, input int eid, input logic eto);
    exp_t e;
    @(posedge clk);
    #2;
    req  = r;
    e.gnt = eg;
    e.id  = eid[1:0];
    e.to  = eto;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    chk({cur_test, " rst gnt"},     {4'b0, gnt},        8'h00);
    chk({cur_test, " rst gnt_vld"}, {7'b0, gnt_valid},  8'h00);
    chk({cur_test, " rst gnt_id"},  {6'b0, gnt_id},     8'h00);
    chk({cur_test, " rst timeout"}, {7'b0, timeout},    8'h00);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int seq[5];

    // Single requester, dropped after 3 grant cycles.
    cur_test = "single";
    do_reset();
    drive(4'b0100, 4'b0100, 2, 1'b0);
    drive(4'b0100, 4'b0100, 2, 1'b0);
    drive(4'b0100, 4'b0100, 2, 1'b0);
    drive(4'b0000, 4'b0000, 0, 1'b0);
    drive(4'b0000, 4'b0000, 0, 1'b0);
    drive(4'b0000, 4'b0000, 0, 1'b0);

    // Priority among 1011: 3 first, then 1 after a one-cycle gap.
    cur_test = "priority";
    do_reset();
    drive(4'b1011, 4'b1000, 3, 1'b0);
    drive(4'b0011, 4'b0000, 0, 1'b0);
    drive(4'b0011, 4'b0010, 1, 1'b0);
    drive(4'b0000, 4'b0000, 0, 1'b0);
    drive(4'b0000, 4'b0000, 0, 1'b0);

    // Hold limit with MAX_HOLD=4: 4 grant cycles, timeout gap, re-grant.
    cur_test = "timeout";
    do_reset();
    repeat (4) drive(4'b0001, 4'b0001, 0, 1'b0);
    drive(4'b0001, 4'b0000, 0, 1'b1);
    drive(4'b0001, 4'b0001, 0, 1'b0);
    drive(4'b0001, 4'b0001, 0, 1'b0);
    drive(4'b0000, 4'b0000, 0, 1'b0);
    drive(4'b0000, 4'b0000, 0, 1'b0);

    // Drop on the same cycle the limit is reached: no timeout.
    cur_test = "drop_vs_limit";
    do_reset();
    repeat (4) drive(4'b0010, 4'b0010, 1, 1'b0);
    drive(4'b0000, 4'b0000, 0, 1'b0);
    drive(4'b0000, 4'b0000, 0, 1'b0);

    // All requesting: rotating order in RR builds, owner 3 repeatedly otherwise.
    cur_test = "all_req";
`ifdef PRIORITY_ARBITER_RR_EN
    seq = '{3, 2, 1, 0, 3};
`else
    seq = '{3, 3, 3, 3, 3};
`endif
    do_reset();
    for (int k = 0; k < 5; k++) begin
      repeat (4) drive(4'b1111, oh(seq[k]), seq[k], 1'b0);
      if (k < 4) drive(4'b1111, 4'b0000, 0, 1'b1);
    end
    drive(4'b0000, 4'b0000, 0, 1'b0);
    drive(4'b0000, 4'b0000, 0, 1'b0);

    // Asynchronous reset while owner 3 holds the grant.
    cur_test = "async_rst";
    do_reset();
    drive(4'b1000, 4'b1000, 3, 1'b0);
    drive(4'b1000, 4'b1000, 3, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst gnt clears",  {4'b0, gnt},       8'h00);
    chk("async_rst vld clears",  {7'b0, gnt_valid}, 8'h00);
    chk("async_rst no timeout",  {7'b0, timeout},   8'h00);
    @(posedge clk);
    #3;
    rst = 1'b0;
    begin
      exp_t e;
      e.gnt = 4'b1000;
      e.id  = 2'd3;
      e.to  = 1'b0;
      exp_q.push_back(e);
    end
    drive(4'b0000, 4'b0000, 0, 1'b0);
    drive(4'b0000, 4'b0000, 0, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_arbiter_4.md
# priority_arbiter_4

Four-requester arbiter that shares one downstream resource, granting it to exactly one requester at a time. The block priority-encodes the request vector, registers a one-hot grant plus a 2-bit grant index, and holds the grant until the owner drops its request or a hold limit expires. A one-cycle release gap separates consecutive grants. It sits between four request sources and the shared datapath, which it steers with `gnt_id`.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner may keep the grant. Legal range is 2..256.
- `clk` input, 1 bit: rising-edge clock.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `req` input, 4 bits: level requests. `req[i]` stays high while requester i wants the resource.
- `gnt` output, 4 bits: one-hot grant, registered. All zeros when there is no owner.
- `gnt_id` output, 2 bits: binary index of the owner. Valid only while `gnt_valid` is 1.
- `gnt_valid` output, 1 bit: equals `|gnt`.
- `timeout` output, 1 bit: one-cycle pulse when a grant is revoked because the hold limit was reached.

## Operation
States: IDLE, GRANT, RELEASE.

Reset values:
- State goes to IDLE.
- `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0.
- `hold_cnt`=0.
- `last`=0 (last owner, used for rotation).

State transitions:
- **IDLE:** if `|req`, load the winner into `gnt`/`gnt_id`, clear `hold_cnt`, and go to GRANT. Otherwise stay in IDLE.
- **GRANT:** `hold_cnt` increments every cycle and saturates at `MAX_HOLD-1`.
  - If `req[gnt_id]`=0 is sampled, clear `gnt` and go to RELEASE.
  - Otherwise, if `hold_cnt`==`MAX_HOLD-1`, clear `gnt`, assert `timeout` for the next cycle, and go to RELEASE.
  - Otherwise, stay in GRANT.
- **RELEASE:** `gnt`=0 for exactly this cycle.
  - Arbitrate exactly as in IDLE: if `|req`, go to GRANT with the new winner. Otherwise go to IDLE.
  - `last` is updated to the outgoing owner on entry to RELEASE.

General rules:
- The winner is chosen among the current `req` bits only. Requests that are asserted and then dropped before they are sampled are never granted.
- If the owner drops its request on the same cycle the limit is reached, the drop wins and `timeout` stays 0.
- Requests from non-owners never pre-empt an active grant.
- `gnt_id` holds its last value while `gnt_valid`=0. Consumers must not use it in that state.
- `hold_cnt` width is `$clog2(MAX_HOLD)`.

## Timing
- **Grant latency:** `req` is sampled high at edge N in IDLE, and `gnt` is high after edge N. That is one cycle from request to grant.
- **Release latency:** the owner's `req` is sampled low at edge N, and `gnt` is 0 after edge N. The next grant, if any, appears after edge N+1. There is one dead cycle between owners, including re-grant to the same requester.
- **Maximum tenure:** `MAX_HOLD` cycles of `gnt` high. `timeout` is high during the RELEASE cycle.
- **Reset mid-grant:** `gnt` clears immediately (asynchronously). There is no RELEASE cycle and no `timeout` pulse.
- **Outputs:** all outputs come directly from flops, with no combinational path from `req`.

## Configuration
- **`PRIORITY_ARBITER_RR_EN` defined:** rotating priority.
  - After a grant to k, the priority order is k-1, k-2, …, then k, descending with wrap-around. The previous owner therefore has the lowest priority.
  - Since `last` resets to 0, the first order after reset is 3, 2, 1, 0.
- **Not defined:** fixed priority 3 > 2 > 1 > 0. `last` is not implemented.

## Structure
- **Package `priority_arbiter_pkg`:**
  - State enum (IDLE, GRANT, RELEASE).
  - `N_REQ` = 4.
  - `ID_W` = 2.
- **Sub-module:** the combinational pick is the team's `priority_encoder_4_2`, with the highest set bit winning. In RR builds it is fed `req` rotated by `last`, and the result is un-rotated with 2-bit modular addition. The pick is qualified by `|req`.

## Test plan
- **Single requester:** reset, then `req`=4'b0100 for 3 cycles then 0. Expect `gnt`=4'b0100 and `gnt_id`=2 starting one cycle after `req`, for 3 cycles, then `gnt`=0 and `timeout`=0.
- **Fixed priority (no macro):** `req`=4'b1011 held until granted. Expect the winner to be 3. Then drop `req[3]`. After the one-cycle gap, expect `gnt`=4'b0010.
- **Timeout:** `MAX_HOLD`=4, `req`=4'b0001 held high. Expect `gnt` high for 4 cycles, then 1 cycle with `gnt`=0 and `timeout`=1, then re-grant to 0.
- **Round robin (macro defined):** `req`=4'b1111 held with `MAX_HOLD`=2. Expect the grant sequence 3, 2, 1, 0, 3, each for 2 cycles, with a 1-cycle gap between grants.
- **Drop versus limit on the same cycle:** the owner drops `req` on the cycle `hold_cnt` reaches `MAX_HOLD-1`. Expect `timeout`=0.
- **Asynchronous reset mid-grant:** assert `rst` between edges while `gnt`=4'b1000. Expect `gnt`=0 immediately. After release of reset with `req`=4'b1000, expect a re-grant one cycle later.
